// File: rtl/intra16_sse.sv
// Scores a 16x16 intra prediction candidate (sum of squared differences) and tracks the best mode.
// Define INTRA16_SSE_SAD_EN to score with sum of absolute differences instead.
module intra16_sse #(
  parameter int BIT_WIDTH  = 8,
  parameter int BLOCK_SIZE = 16,
  parameter int MODE_W     = 2,
`ifdef INTRA16_SSE_SAD_EN
  localparam int SSE_W = BIT_WIDTH + 2*$clog2(BLOCK_SIZE)
`else
  localparam int SSE_W = 2*BIT_WIDTH + 2*$clog2(BLOCK_SIZE)
`endif
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     start_i,
  input  logic                                     first_i,
  input  logic [MODE_W-1:0]                        mode_i,
  input  logic [BIT_WIDTH*BLOCK_SIZE*BLOCK_SIZE-1:0] src_i,
  input  logic [BIT_WIDTH*BLOCK_SIZE*BLOCK_SIZE-1:0] pred_i,
  output logic [SSE_W-1:0]                         sse_o,
  output logic [SSE_W-1:0]                         best_sse_o,
  output logic [MODE_W-1:0]                        best_mode_o,
  output logic                                     busy_o,
  output logic                                     done_o
);

  localparam int LOG2_BS = $clog2(BLOCK_SIZE);
  localparam int ROW_W   = SSE_W - LOG2_BS;

  typedef enum logic [3:0] {
    IDLE = 4'b0001,
    ACC  = 4'b0010,
    CMP  = 4'b0100,
    DONE = 4'b1000
  } state_t;

  state_t               state_q;
  logic [LOG2_BS-1:0]   row_q;
  logic [SSE_W-1:0]     acc_q;
  logic [SSE_W-1:0]     acc_d;
  logic                 first_q;
  logic [MODE_W-1:0]    mode_q;
  logic [SSE_W-1:0]     sse_q;
  logic [SSE_W-1:0]     bestSse_q;
  logic [MODE_W-1:0]    bestMode_q;
  logic                 busy_q;
  logic                 done_q;

  logic [BIT_WIDTH-1:0] srcPix;
  logic [BIT_WIDTH-1:0] predPix;
  logic [BIT_WIDTH-1:0] mag;
  logic [ROW_W-1:0]     rowSum;
`ifndef INTRA16_SSE_SAD_EN
  logic [2*BIT_WIDTH-1:0] sq;
`endif

  // |src - pred| is formed directly so the square needs only an unsigned BIT_WIDTH multiplier.
  always_comb begin
    srcPix  = '0;
    predPix = '0;
    mag     = '0;
    rowSum  = '0;
`ifndef INTRA16_SSE_SAD_EN
    sq      = '0;
`endif
    for (int c = 0; c < BLOCK_SIZE; c++) begin
      srcPix  = src_i[BIT_WIDTH*(int'(row_q)*BLOCK_SIZE + c) +: BIT_WIDTH];
      predPix = pred_i[BIT_WIDTH*(int'(row_q)*BLOCK_SIZE + c) +: BIT_WIDTH];
      mag     = (srcPix >= predPix) ? (srcPix - predPix) : (predPix - srcPix);
`ifdef INTRA16_SSE_SAD_EN
      rowSum  = rowSum + {{(ROW_W-BIT_WIDTH){1'b0}}, mag};
`else
      sq      = {{BIT_WIDTH{1'b0}}, mag} * {{BIT_WIDTH{1'b0}}, mag};
      rowSum  = rowSum + {{(ROW_W-2*BIT_WIDTH){1'b0}}, sq};
`endif
    end
    acc_d = acc_q + {{LOG2_BS{1'b0}}, rowSum};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      row_q      <= '0;
      acc_q      <= '0;
      first_q    <= 1'b0;
      mode_q     <= '0;
      sse_q      <= '0;
      bestSse_q  <= '1;
      bestMode_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            mode_q  <= mode_i;
            first_q <= first_i;
            row_q   <= '0;
            acc_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ACC;
          end
        end
        ACC: begin
          acc_q <= acc_d;
          row_q <= row_q + LOG2_BS'(1);
          if (row_q == LOG2_BS'(BLOCK_SIZE-1)) state_q <= CMP;
        end
        CMP: begin
          sse_q <= acc_q;
          // Strict compare keeps the earlier mode on a tie.
          if (first_q || (acc_q < bestSse_q)) begin
            bestSse_q  <= acc_q;
            bestMode_q <= mode_q;
          end
          done_q  <= 1'b1;
          state_q <= DONE;
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign sse_o       = sse_q;
  assign best_sse_o  = bestSse_q;
  assign best_mode_o = bestMode_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;

endmodule
